mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer. It computes a WIDTH-bit result over WIDTH/DIGIT cycles by reusing one DIGIT-bit carry-chain slice.
- Handles operand capture, carry propagation between digits, subtraction by two's complement, and result handoff over valid/ready handshakes.
- Sits between operand producers and a result consumer wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, width of the shared adder slice in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for subtraction, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, RUN, DONE. The reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, digit index=0, carry=0.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE. Both are decoded from state, with no combinational input-to-output path.
- IDLE:
  - On in_valid && in_ready, latch A, B' = sub ? ~b : b, carry = sub, and sign bits of a and B'.
  - Clear the digit index and sum; go to RUN.
- RUN, each cycle at digit index i:
  - Slice computes A[i] + B'[i] + carry.
  - The carry must enter bit 0 of the slice.
  - Write the slice sum into sum[i*DIGIT +: DIGIT]; register the slice carry-out as carry.
  - Increment i. After the last digit (i = WIDTH/DIGIT - 1), go to DONE.
- Latency: out_valid rises exactly WIDTH/DIGIT cycles after the accept edge (4 cycles at defaults).
- DONE:
  - cout = final carry.
  - ovf = (signA == signB') && (sum[WIDTH-1] != signA).
  - Hold sum, cout and ovf stable until out_valid && out_ready, then go to IDLE.
  - No same-cycle re-accept; next accept is no earlier than the cycle after handoff.
- in_valid is ignored in RUN and DONE. a, b and sub may change freely after the accept edge without affecting the result.
- sum/cout/ovf are don't-care outside DONE except at reset. They retain their last values in IDLE, and sum is cleared on accept.
- rst asserted in any state, including mid-RUN, aborts the operation, restores all reset values next edge, and discards the result.
- Wrap-around: the carry out of the MSB is reported on cout only, never folded into sum.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE); localparam NDIG = WIDTH/DIGIT; digit-index width = clog2(NDIG), min 1.
- Sub-module add_slice (DIGIT-bit ripple full-adder chain).
  - Ports: x, y, ci, s, co.
  - ci must feed bit 0; it is instantiated once and shared across all digits.

Test Plan:
- 0x00FF + 0x0001, sub=0 -> out_valid 4 cycles after accept; sum=0x0100, cout=0, ovf=0.
- 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0. Then 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and operands -> out_valid stays 1, sum/cout/ovf stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle.
- Reset after 2 RUN cycles of 0x1234 + 0x1111 -> next cycle in_ready=1, out_valid=0, sum=0. A new 0x0001 + 0x0001 yields 0x0002 after 4 cycles.
- Back-to-back: issue 0x0F0F + 0x00F1 and 0x0001 - 0x0001 with out_ready=1 and in_valid held -> results 0x1000 (cout=0) and 0x0000 (cout=1). Accepts are 6 cycles apart (accept, 4 RUN, DONE).

Source files
------------

// File: rtl/mp_add_seq_pkg.sv
// mp_add_seq_pkg: shared state encoding and sizing helpers for the digit-serial adder
package mp_add_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;
  localparam int NDIG = WIDTH_DEF / DIGIT_DEF;
  function automatic int idx_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction
endpackage

// File: rtl/mp_add_seq_slice.sv
// add_slice: DIGIT-bit ripple full-adder chain, carry-in enters bit 0
module add_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign co = c[DIGIT];
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract reusing one DIGIT-bit slice over WIDTH/DIGIT cycles
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int ND = WIDTH / DIGIT;
  localparam int IW = idx_w(ND);
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0] idx;
  logic carry, sa, sb, co, last;
  logic [DIGIT-1:0] ss;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = idx == IW'(ND - 1);
  add_slice #(.DIGIT(DIGIT)) u_slice (
    .x (ra[idx*DIGIT +: DIGIT]),
    .y (rb[idx*DIGIT +: DIGIT]),
    .ci(carry),
    .s (ss),
    .co(co)
  );
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && in_valid)  ? RUN  :
              (state == RUN  && last)      ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra    <= a;
      rb    <= sub ? ~b : b;
      sa    <= a[WIDTH-1];
      sb    <= sub ^ b[WIDTH-1];
      carry <= sub;
      idx   <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      sum[idx*DIGIT +: DIGIT] <= ss;
      carry <= co;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout <= co;
        ovf  <= (sa == sb) && (ss[DIGIT-1] != sa);
      end
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed checks of add/sub results, latency, backpressure, reset abort, back-to-back
module tb_mp_add_seq;
  logic clk = 0, rst = 1, in_valid = 0, sub = 0, out_ready = 0;
  logic in_ready, out_valid, cout, ovf;
  logic [15:0] a = 0, b = 0, sum;
  int total = 0, bad = 0;

  mp_add_seq #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                    input logic [15:0] es, input logic ec, input logic eo, input int hold);
    a = xa; b = xb; sub = xs; in_valid = 1;
    tick();
    chk({tag, " accepted"}, in_ready, 0);
    in_valid = 0; a = 16'h5A5A; b = 16'hA5A5; sub = ~xs;
    repeat (3) tick();
    chk({tag, " early"}, out_valid, 0);
    tick();
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " ovf"}, ovf, eo);
    for (int k = 0; k < hold; k++) begin
      in_valid = ~in_valid; a = 16'($urandom); b = 16'($urandom); sub = ~sub;
      tick();
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold ready"}, in_ready, 0);
      chk({tag, " hold sum"}, {ovf, cout, sum}, {eo, ec, es});
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, " handoff"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset state", {in_ready, out_valid, cout, ovf}, 4'b1000);
    chk("reset sum", sum, 0);
    rst = 0;
    tick();
    op("add 00ff+0001", 16'h00FF, 16'h0001, 0, 16'h0100, 0, 0, 0);
    op("add ffff+0001", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
    op("add 7fff+0001", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
    op("sub 0005-0007", 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0, 0);
    op("sub 8000-0001", 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 3);
    a = 16'h1234; b = 16'h1111; sub = 0; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort flags", {in_ready, out_valid, cout, ovf}, 4'b1000);
    chk("abort sum", sum, 0);
    op("add 0001+0001", 16'h0001, 16'h0001, 0, 16'h0002, 0, 0, 0);
    a = 16'h0F0F; b = 16'h00F1; sub = 0; in_valid = 1; out_ready = 1;
    tick();
    chk("b2b first accept", in_ready, 0);
    a = 16'h0001; b = 16'h0001; sub = 1;
    repeat (3) tick();
    chk("b2b first early", out_valid, 0);
    tick();
    chk("b2b first valid", out_valid, 1);
    chk("b2b first result", {cout, sum}, {1'b0, 16'h1000});
    tick();
    chk("b2b idle gap", in_ready, 1);
    tick();
    chk("b2b second accept", in_ready, 0);
    in_valid = 0;
    repeat (4) tick();
    chk("b2b second valid", out_valid, 1);
    chk("b2b second result", {cout, sum}, {1'b1, 16'h0000});
    tick();
    chk("b2b handoff", in_ready, 1);
    out_ready = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
